mac_ofm_writer: RTL and testbench
=================================

// Module: mac_ofm_writer
// PURPOSE
//  Consumer end of the MAC lane OFM stream (mac_lane_ofm_port: fp32 data + output_end).
//  - Accepts finished fp32 results and packs PACK words per beat.
//  - Writes beats to the output buffer at incrementing addresses.
//  - Closes a tile on output_end: flushes a partial beat with strobes and pulses done.
// PARAMETERS
//  PACK    4   fp32 words per write beat (power of 2, >=2)
//  ADDR_W  16  output-buffer word-beat address width
// PORTS
//  i_clk                       in   1        clock
//  i_reset                     in   1        reset, asynchronous, active-low
//  i_start                     in   1        tile start; loads i_base_addr (honoured in IDLE only)
//  i_base_addr                 in   ADDR_W   first beat address of the tile
//  mac_ofm_writer_o_ofm_ready  out  1        OFM input ready
//  mac_ofm_writer_i_ofm_valid  in   1        OFM input valid
//  mac_ofm_writer_i_ofm_data   in   mac_lane_ofm_port  {data[31:0], output_end}
//  o_wr_valid                  out  1        write beat valid
//  i_wr_ready                  in   1        write beat accepted
//  o_wr_addr                   out  ADDR_W   beat address
//  o_wr_data                   out  32*PACK  slot k at bits [32k+31:32k]
//  o_wr_strb                   out  PACK     per-slot write enable
//  o_wr_last                   out  1        beat closes the tile
//  o_busy                      out  1        state != IDLE
//  o_done                      out  1        one-cycle pulse when the last beat is accepted
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; slot counter, address, data and strobe registers cleared.
//  FSM states IDLE, FILL, SEND:
//   IDLE: ofm_ready=0. On i_start: addr<=i_base_addr, cnt<=0, strb<=0, then FILL.
//   FILL: ofm_ready=1. On accept: slot[cnt]<=data, strb[cnt]<=1, cnt++.
//    - If cnt==PACK-1 or output_end=1: go to SEND.
//    - Set last<=output_end.
//   SEND: ofm_ready=0. o_wr_valid=1; addr, data, strb and last held stable until i_wr_ready.
//    - On accept with last=1: addr+=1, done=1 for 1 cycle, go to IDLE.
//    - On accept with last=0: addr+=1, cnt<=0, strb<=0, data<=0, go to FILL.
//  Latency: o_wr_valid is asserted in the cycle after the closing word is accepted.
//  Throughput: one beat per PACK+1 cycles when i_wr_ready is held high.
//  Unwritten slots of a partial beat: data=0, strb=0.
//  output_end on the first slot: beat sent with strb=0...01, last=1.
//  Address arithmetic is modulo 2^ADDR_W; FFF..F wraps to 0 silently.
//  i_start outside IDLE is ignored. i_start in the same cycle o_done pulses is ignored; the next
//   tile needs i_start while in IDLE.
//  OFM valid in IDLE is not consumed; the producer stalls.
//  Reset asserted mid-operation: immediate return to reset values; any partial beat is discarded.
// CONFIGURATION
//  MAC_OFM_WRITER_RELU_EN defined: ReLU on capture. Any word with sign bit 1 is stored as
//   32'h0000_0000 (covers -0.0, negative numbers and negative NaN); others pass unchanged.
//  Undefined: data is stored bit-exact.
// STRUCTURE
//  mac_pkg holds:
//   - mac_lane_ofm_port (existing)
//   - new localparam MAC_OFM_PACK_DEF=4
//   - typedef enum logic[1:0] mac_ofm_wr_state_e {IDLE, FILL, SEND}
//  No sub-module: single flat module with FSM, slot counter, packer regs and address counter.
// TESTING
//  1 Reset, start base=0x0010, 8 words 1.0..8.0, output_end on word 8, wr_ready=1
//    -> 2 beats: addr 0x10 then 0x11; strb=4'hF; last=0 then 1; done pulses once.
//  2 Start base=0x0020, 3 words with output_end on the 3rd
//    -> 1 beat: addr 0x20, strb=4'h7, slot3=0, last=1.
//  3 One full beat, wr_ready held low for 5 cycles
//    -> addr/data/strb stable and ofm_ready=0 throughout; beat accepted on the 6th cycle.
//  4 base=0xFFFF, 8 words
//    -> beat addresses 0xFFFF then 0x0000.
//  5 Words 0xBF80_0000 (-1.0) and 0x8000_0000
//    -> with RELU_EN both stored as 0; without it both stored unchanged.
//  6 Reset pulse after 2 words accepted
//    -> all outputs 0, no beat issued; i_start while busy is ignored.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC lane types: OFM stream port, writer FSM states and the capture helper.
// MAC_OFM_WRITER_RELU_EN selects ReLU-on-capture in mac_ofm_capture().
package mac_pkg;

    localparam int MAC_OFM_PACK_DEF = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        output_end;
    } mac_lane_ofm_port;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } mac_ofm_wr_state_e;

    // Sign bit set covers -0.0, negative numbers and negative NaN alike.
    function automatic logic [31:0] mac_ofm_capture(input logic [31:0] word);
`ifdef MAC_OFM_WRITER_RELU_EN
        mac_ofm_capture = word[31] ? 32'h0000_0000 : word;
`else
        mac_ofm_capture = word;
`endif
    endfunction

endpackage

// File: rtl/mac_ofm_writer.sv
// Packs fp32 OFM results PACK per beat and writes them to the output buffer.
// Optional ReLU on capture: define MAC_OFM_WRITER_RELU_EN.
module mac_ofm_writer
    import mac_pkg::*;
#(
    parameter int PACK   = MAC_OFM_PACK_DEF,
    parameter int ADDR_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    output logic                   mac_ofm_writer_o_ofm_ready,
    input  logic                   mac_ofm_writer_i_ofm_valid,
    input  mac_lane_ofm_port       mac_ofm_writer_i_ofm_data,
    output logic                   o_wr_valid,
    input  logic                   i_wr_ready,
    output logic [ADDR_W-1:0]      o_wr_addr,
    output logic [32*PACK-1:0]     o_wr_data,
    output logic [PACK-1:0]        o_wr_strb,
    output logic                   o_wr_last,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int CNT_W = $clog2(PACK);

    mac_ofm_wr_state_e   state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [32*PACK-1:0]  data_q, data_d;
    logic [PACK-1:0]     strb_q, strb_d;
    logic                last_q, last_d;
    logic                done_q, done_d;

    // Handshake: a word/beat transfers on the rising edge where valid and ready are both high.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the tile just closed.
                if (i_start && !done_q) begin
                    addr_d  = i_base_addr;
                    cnt_d   = '0;
                    strb_d  = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mac_ofm_writer_i_ofm_valid) begin
                    data_d[32*cnt_q +: 32] =
                        mac_ofm_capture(mac_ofm_writer_i_ofm_data.data);
                    strb_d[cnt_q] = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                    last_d        = mac_ofm_writer_i_ofm_data.output_end;
                    if (cnt_q == CNT_W'(PACK - 1) || mac_ofm_writer_i_ofm_data.output_end) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (i_wr_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        strb_d  = '0;
                        data_d  = '0;
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mac_ofm_writer_o_ofm_ready = (state_q == FILL);
    assign o_wr_valid                 = (state_q == SEND);
    assign o_wr_addr                  = addr_q;
    assign o_wr_data                  = data_q;
    assign o_wr_strb                  = strb_q;
    assign o_wr_last                  = last_q;
    assign o_busy                     = (state_q != IDLE);
    assign o_done                     = done_q;

endmodule

// File: tb/tb_mac_ofm_writer.sv
// Self-checking bench for mac_ofm_writer: table-driven tiles, random tiles and corner sequences.
module tb_mac_ofm_writer;
    import mac_pkg::*;

    localparam int PACK   = 4;
    localparam int ADDR_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic                  ofm_ready;
    logic                  ofm_valid;
    mac_lane_ofm_port      ofm_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [32*PACK-1:0]    wr_data;
    logic [PACK-1:0]       wr_strb;
    logic                  wr_last;
    logic                  busy;
    logic                  done;

    mac_ofm_writer #(.PACK(PACK), .ADDR_W(ADDR_W)) dut (
        .i_clk                      (clk),
        .i_reset                    (rst_n),
        .i_start                    (start),
        .i_base_addr                (base_addr),
        .mac_ofm_writer_o_ofm_ready (ofm_ready),
        .mac_ofm_writer_i_ofm_valid (ofm_valid),
        .mac_ofm_writer_i_ofm_data  (ofm_data),
        .o_wr_valid                 (wr_valid),
        .i_wr_ready                 (wr_ready),
        .o_wr_addr                  (wr_addr),
        .o_wr_data                  (wr_data),
        .o_wr_strb                  (wr_strb),
        .o_wr_last                  (wr_last),
        .o_busy                     (busy),
        .o_done                     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]         w[0:15];
    logic [ADDR_W-1:0]   exp_addr_q[$];
    logic [32*PACK-1:0]  exp_data_q[$];
    logic [PACK-1:0]     exp_strb_q[$];
    logic                exp_last_q[$];

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                n;
        int                mode;
        int                stall;
        int                exp_beats;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_store(input logic [31:0] x);
`ifdef MAC_OFM_WRITER_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    // mode 0: 1.0..8.0 then random; mode 1: random; mode 2: negatives first
    task automatic fill_words(input int mode);
        logic [31:0] floats[0:7];
        floats = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            if (mode == 0 && i < 8) w[i] = floats[i];
            if (mode == 2 && i == 0) w[i] = 32'hBF80_0000;
            if (mode == 2 && i == 1) w[i] = 32'h8000_0000;
        end
    endtask

    // Reference: words chunked PACK per beat at base+beat, last beat carries the end flag.
    task automatic model_tile(input logic [ADDR_W-1:0] base, input int n);
        int nb;
        logic [32*PACK-1:0] d;
        logic [PACK-1:0]    s;
        nb = (n + PACK - 1) / PACK;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            s = '0;
            for (int k = 0; k < PACK; k++) begin
                if (b * PACK + k < n) begin
                    d[32*k +: 32] = ref_store(w[b * PACK + k]);
                    s[k] = 1'b1;
                end
            end
            exp_addr_q.push_back(base + ADDR_W'(b));
            exp_data_q.push_back(d);
            exp_strb_q.push_back(s);
            exp_last_q.push_back(b == nb - 1);
        end
    endtask

    task automatic run_tile(input logic [ADDR_W-1:0] base, input int n, input int stall,
                            input int exp_beats);
        int idx, beats, cyc;
        logic acc_in, acc_wr, lastb, done_seen;
        exp_addr_q.delete(); exp_data_q.delete(); exp_strb_q.delete(); exp_last_q.delete();
        model_tile(base, n);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        idx = 0; beats = 0; cyc = 0; done_seen = 1'b0; lastb = 1'b0;
        while (!done_seen && cyc < 400) begin
            ofm_valid = (idx < n);
            ofm_data.data = (idx < n) ? w[idx] : 32'h0;
            ofm_data.output_end = (idx == n - 1);
            wr_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, stall) == 0);
            #1;
            acc_in = ofm_valid && ofm_ready;
            acc_wr = wr_valid && wr_ready;
            if (acc_wr) begin
                beats++;
                check("ofm_ready_low_in_send", ofm_ready, 0);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                    lastb = 1'b1;
                end else begin
                    check("beat_addr", wr_addr, exp_addr_q.pop_front());
                    check("beat_data", wr_data, exp_data_q.pop_front());
                    check("beat_strb", wr_strb, exp_strb_q.pop_front());
                    lastb = exp_last_q.pop_front();
                    check("beat_last", wr_last, lastb);
                end
            end
            @(posedge clk);
            if (acc_in) idx++;
            @(negedge clk);
            cyc++;
            if (acc_wr && lastb) done_seen = 1'b1;
        end
        ofm_valid = 1'b0;
        wr_ready = 1'b0;
        check("tile_finished_in_budget", done_seen, 1);
        check("done_pulse", done, 1);
        check("busy_after_tile", busy, 0);
        check("beat_count", beats, exp_beats);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        vec_t vecs[7];
        logic [127:0] snap;
        start = 1'b0; base_addr = '0; ofm_valid = 1'b0; ofm_data = '0; wr_ready = 1'b0;

        // clock/reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {wr_valid, ofm_ready, busy, done, wr_last, wr_strb, wr_addr}, 0);
        check("reset_data", wr_data, 0);
        rst_n = 1'b1;

        vecs[0] = '{16'h0010, 8,  0, 0, 2};
        vecs[1] = '{16'h0020, 3,  1, 0, 1};
        vecs[2] = '{16'hFFFF, 8,  1, 0, 2};
        vecs[3] = '{16'h0030, 2,  2, 0, 1};
        vecs[4] = '{16'h0040, 1,  1, 1, 1};
        vecs[5] = '{16'h0050, 12, 1, 2, 3};
        vecs[6] = '{16'h0070, 5,  2, 3, 2};
        for (int v = 0; v < 7; v++) begin
            fill_words(vecs[v].mode);
            run_tile(vecs[v].base, vecs[v].n, vecs[v].stall, vecs[v].exp_beats);
        end

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, 13);
            fill_words($urandom_range(0, 2));
            run_tile(ADDR_W'($urandom), n, $urandom_range(0, 3), (n + PACK - 1) / PACK);
        end

        // Full beat held by wr_ready low for 5 cycles, accepted on the 6th.
        fill_words(0);
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0060;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ofm_valid = 1'b1; ofm_data.data = w[i]; ofm_data.output_end = (i == 3);
            @(negedge clk);
        end
        ofm_valid = 1'b1;
        snap = {ref_store(w[3]), ref_store(w[2]), ref_store(w[1]), ref_store(w[0])};
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_valid", wr_valid, 1);
            check("stall_ofm_ready", ofm_ready, 0);
            check("stall_addr", wr_addr, 16'h0060);
            check("stall_data", wr_data, snap);
            check("stall_strb", wr_strb, 4'hF);
            @(negedge clk);
        end
        wr_ready = 1'b1;
        #1;
        check("stall_accept_valid", wr_valid, 1);
        @(negedge clk);
        wr_ready = 1'b0; ofm_valid = 1'b0;
        check("stall_done", done, 1);
        check("stall_busy", busy, 0);

        // Reset after two words: everything clears and no beat follows.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0090;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ofm_valid = 1'b1; ofm_data.data = w[i]; ofm_data.output_end = 1'b0;
            @(negedge clk);
        end
        ofm_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {wr_valid, ofm_ready, busy, done, wr_last, wr_strb, wr_addr}, 0);
        check("midreset_data", wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        begin
            int beats_seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (wr_valid || busy) beats_seen++;
            end
            check("no_beat_after_reset", beats_seen, 0);
        end
        wr_ready = 1'b0;

        // Start while busy and start on the done pulse are both ignored.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h00A0;
        @(negedge clk);
        start = 1'b0;
        ofm_valid = 1'b1; ofm_data.data = 32'h3F80_0000; ofm_data.output_end = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 16'h00BB;
        ofm_data.data = 32'h4000_0000; ofm_data.output_end = 1'b1;
        @(negedge clk);
        start = 1'b0; ofm_valid = 1'b0; wr_ready = 1'b1;
        #1;
        check("busy_start_valid", wr_valid, 1);
        check("busy_start_addr", wr_addr, 16'h00A0);
        check("busy_start_strb", wr_strb, 4'h3);
        check("busy_start_last", wr_last, 1);
        check("busy_start_data", wr_data, {64'h0, 32'h4000_0000, 32'h3F80_0000});
        @(negedge clk);
        wr_ready = 1'b0;
        check("done_before_restart", done, 1);
        start = 1'b1; base_addr = 16'h00CC; ofm_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_on_done_ignored", busy, 0);
        check("idle_ofm_ready", ofm_ready, 0);
        @(negedge clk);
        ofm_valid = 1'b0;
        check("still_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
